// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB register writer.
//   sccb_state_e   : writer FSM states
//   BIT_COUNT      : bits serialized per 3-phase write (3 x (8 data + 1 don't-care))
//   X_BIT*         : don't-care (ack) bit positions, sio_d released during these
//   DEF_DEV_ID     : default SCCB write ID
//   DEF_RESET_WORD : default {reg,data} word that needs a settle wait afterwards
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_START  = 3'd2,
    ST_BIT    = 3'd3,
    ST_STOP   = 3'd4,
    ST_SETTLE = 3'd5,
    ST_DONE   = 3'd6,
    ST_GAP    = 3'd7
  } sccb_state_e;

  localparam int          BIT_COUNT      = 27;
  localparam int          X_BIT0         = 8;
  localparam int          X_BIT1         = 17;
  localparam int          X_BIT2         = 26;
  localparam int          GAP_CYCLES     = 2;
  localparam logic [7:0]  DEF_DEV_ID     = 8'h60;
  localparam logic [15:0] DEF_RESET_WORD = 16'h1280;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic logic is_x_bit(input logic [4:0] idx);
    return (idx == 5'(X_BIT0)) || (idx == 5'(X_BIT1)) || (idx == 5'(X_BIT2));
  endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-period tick generator for the SCCB bus timing.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   en   : counting enable; low holds the divider at zero so that a new
//          transaction always starts with a full quarter
//   tick : high for one clk cycle at the end of every QUARTER-cycle period
module sccb_tick_gen #(
  parameter int QUARTER = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == CW'(QUARTER - 1));
    cnt_d = cnt_q;
    if (!en || tick) cnt_d = '0;
    else             cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sccb_writer.sv
// SCCB (3-phase write) register writer.
// Request/advance handshake: while reg_ok is high, data_in holds the pending
// {reg_addr, reg_data} word. The writer samples it only in IDLE, writes it, and
// answers with a single-cycle sccb_ok once the word is complete; the upstream
// source then advances to its next word. A word is never consumed without sccb_ok.
//   clk, rst   : system clock, asynchronous active-high reset
//   reg_ok     : word request
//   data_in    : {reg_addr[15:8], reg_data[7:0]}
//   sccb_ok    : one-cycle "word written" pulse
//   busy       : high from leaving IDLE through the sccb_ok pulse
//   sio_c      : SCCB clock
//   sio_d_out  : SCCB data value
//   sio_d_oe   : SCCB data drive enable (low = released)
//   state_dbg  : current FSM state (sccb_state_e encoding)
module sccb_writer
  import sccb_pkg::*;
#(
  parameter int          QUARTER    = 63,
  parameter logic [7:0]  DEV_ID     = DEF_DEV_ID,
  parameter int          PWRUP_WAIT = 25000,
  parameter int          RST_WAIT   = 25000,
  parameter logic [15:0] RESET_WORD = DEF_RESET_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_ok,
  input  logic [15:0] data_in,
  output logic        sccb_ok,
  output logic        busy,
  output logic        sio_c,
  output logic        sio_d_out,
  output logic        sio_d_oe,
  output logic [2:0]  state_dbg
);

  localparam int WAIT_MAX0 = max3(PWRUP_WAIT, RST_WAIT, QUARTER);
  localparam int WAIT_MAX  = (WAIT_MAX0 > GAP_CYCLES) ? WAIT_MAX0 : GAP_CYCLES;
  localparam int WW        = $clog2(WAIT_MAX + 1);

  sccb_state_e   state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [1:0]    qcnt_q, qcnt_d;
  logic [4:0]    bcnt_q, bcnt_d;
  logic [15:0]   word_q, word_d;
  logic          c_q, c_d, d_q, d_d, oe_q, oe_d, ok_q, ok_d, busy_q, busy_d;
  logic          tick, tick_en;
  logic [26:0]   frame;

  assign tick_en = (state_q == ST_START) || (state_q == ST_BIT) || (state_q == ST_STOP);

  sccb_tick_gen #(.QUARTER(QUARTER)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .tick (tick)
  );

  // Don't-care slots carry 1 but are never driven (oe low).
  assign frame = {DEV_ID, 1'b1, word_q[15:8], 1'b1, word_q[7:0], 1'b1};

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    qcnt_d  = qcnt_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    case (state_q)
      ST_PWRUP: begin
        if (wcnt_q == WW'(PWRUP_WAIT - 1)) begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else wcnt_d = wcnt_q + 1'b1;
      end
      ST_IDLE: begin
        if (reg_ok) begin
          word_d  = data_in;
          state_d = ST_START;
          qcnt_d  = '0;
          bcnt_d  = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          qcnt_d = qcnt_q + 1'b1;
          if (qcnt_q == 2'd1) begin
            state_d = ST_BIT;
            qcnt_d  = '0;
          end
        end
      end
      ST_BIT: begin
        if (tick) begin
          qcnt_d = qcnt_q + 1'b1;
          if (qcnt_q == 2'd3) begin
            if (bcnt_q == 5'(BIT_COUNT - 1)) state_d = ST_STOP;
            else                             bcnt_d  = bcnt_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          qcnt_d = qcnt_q + 1'b1;
          if (qcnt_q == 2'd3) begin
            state_d = (word_q == RESET_WORD) ? ST_SETTLE : ST_DONE;
            wcnt_d  = '0;
          end
        end
      end
      ST_SETTLE: begin
        if (wcnt_q == WW'(RST_WAIT - 1)) begin
          state_d = ST_DONE;
          wcnt_d  = '0;
        end else wcnt_d = wcnt_q + 1'b1;
      end
      ST_DONE: begin
        state_d = ST_GAP;
        wcnt_d  = '0;
      end
      ST_GAP: begin
        // Upstream's word register lags the advance by a cycle; don't look at reg_ok yet.
        if (wcnt_q == WW'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else wcnt_d = wcnt_q + 1'b1;
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  // Bus pins are decoded from the current state and registered, so they lag the
  // state by one cycle uniformly; quarter lengths are unaffected.
  always_comb begin
    c_d    = 1'b1;
    d_d    = 1'b1;
    oe_d   = 1'b1;
    ok_d   = (state_q == ST_DONE);
    busy_d = (state_q == ST_START) || (state_q == ST_BIT) || (state_q == ST_STOP) ||
             (state_q == ST_SETTLE) || (state_q == ST_DONE);
    case (state_q)
      ST_START: begin
        d_d = 1'b0;
        c_d = (qcnt_q == 2'd0);
      end
      ST_BIT: begin
        c_d  = qcnt_q[1];
        d_d  = frame[5'(BIT_COUNT - 1) - bcnt_q];
        oe_d = !is_x_bit(bcnt_q);
      end
      ST_STOP: begin
        c_d = (qcnt_q != 2'd0);
        d_d = qcnt_q[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PWRUP;
      wcnt_q  <= '0;
      qcnt_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      c_q     <= 1'b1;
      d_q     <= 1'b1;
      oe_q    <= 1'b1;
      ok_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      qcnt_q  <= qcnt_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      c_q     <= c_d;
      d_q     <= d_d;
      oe_q    <= oe_d;
      ok_q    <= ok_d;
      busy_q  <= busy_d;
    end
  end

  assign sio_c     = c_q;
  assign sio_d_out = d_q;
  assign sio_d_oe  = oe_q;
  assign sccb_ok   = ok_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sccb_writer.sv
module tb_sccb_writer;
  import sccb_pkg::*;

  localparam int NW = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_ok = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        sccb_ok, busy, sio_c, sio_d_out, sio_d_oe;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  sccb_writer #(
    .QUARTER(2), .DEV_ID(8'h60), .PWRUP_WAIT(5), .RST_WAIT(10), .RESET_WORD(16'h1280)
  ) dut (
    .clk(clk), .rst(rst), .reg_ok(reg_ok), .data_in(data_in),
    .sccb_ok(sccb_ok), .busy(busy), .sio_c(sio_c), .sio_d_out(sio_d_out),
    .sio_d_oe(sio_d_oe), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  int          lat_q[$];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-computed: 114 quarters * 2 cycles = 228; reset word adds RST_WAIT=10.
  task automatic push_expected(input logic [15:0] w);
    exp_q.push_back({8'h60, w});
    lat_q.push_back((w == 16'h1280) ? 238 : 228);
  endtask

  // ---------------- upstream word source (driver) ----------------
  logic [15:0] words [NW] = '{16'hFF01, 16'h1280, 16'hA55A, 16'h3C96};
  int          idx = 0;

  always @(negedge clk) begin
    if (!rst && idx < NW) begin
      if (sccb_ok && reg_ok) begin
        idx++;
        if (idx < NW) begin
          data_in = words[idx];
          push_expected(words[idx]);
        end else begin
          reg_ok = 1'b0;
        end
      end else if (idx == 2 && busy) begin
        // Scribble on data_in while word 2 is in flight.
        data_in = 16'($urandom_range(0, 65535));
      end
    end
  end

  // ---------------- bus monitor ----------------
  logic        prev_c = 1'b1, prev_d = 1'b1, prev_ok = 1'b0;
  logic        in_frame = 1'b0;
  int          edges = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          ok_cnt = 0;
  logic [26:0] frame, mask;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      edges    = 0;
    end else begin
      cyc++;
      if (!in_frame && prev_c && sio_c && prev_d && !sio_d_out && sio_d_oe) begin
        in_frame  = 1'b1;
        edges     = 0;
        start_cyc = cyc;
        frame     = '0;
        mask      = '0;
      end else if (in_frame && !prev_c && sio_c && edges < 27) begin
        frame = {frame[25:0], sio_d_out};
        mask  = {mask[25:0], sio_d_oe};
        edges++;
      end else if (in_frame && prev_c && sio_c && !prev_d && sio_d_out && edges >= 27) begin
        in_frame = 1'b0;
        check("frame_expected", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0)
          check("frame_data", {frame[26:19], frame[17:10], frame[8:1]}, exp_q.pop_front());
        check("frame_x_release", mask, 27'h7FBFDFE);
      end
      if (sccb_ok && !prev_ok) begin
        ok_cnt++;
        check("ok_expected", (lat_q.size() != 0), 1'b1);
        if (lat_q.size() != 0) check("ok_latency", cyc - start_cyc, lat_q.pop_front());
      end
      if (prev_ok) check("ok_pulse_width", sccb_ok, 1'b0);
    end
    prev_c  = sio_c;
    prev_d  = sio_d_out;
    prev_ok = sccb_ok;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic got;
    repeat (3) @(negedge clk);
    data_in = words[0];
    reg_ok  = 1'b1;
    push_expected(words[0]);
    check("reset_outputs", {sio_c, sio_d_out, sio_d_oe, sccb_ok, busy}, 5'b11100);
    check("reset_state", state_dbg, ST_PWRUP);
    rst = 1'b0;

    // PWRUP 5 cycles + IDLE capture 1 cycle: bus idle after edges 1..6.
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("pwrup_idle_bus", {sio_c, sio_d_out, sio_d_oe, busy, sccb_ok}, 5'b11100);
    end
    @(negedge clk);
    check("start_condition", {sio_c, sio_d_out, sio_d_oe, busy}, 4'b1011);

    // Abort word 3 at bit 12.
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (idx == 3 && in_frame && edges == 12) got = 1'b1;
    end
    check("reach_bit12_word3", got, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_outputs", {sio_c, sio_d_out, sio_d_oe, sccb_ok, busy}, 5'b11100);
    check("abort_state", state_dbg, ST_PWRUP);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (idx == NW) got = 1'b1;
    end
    check("all_words_done", got, 1'b1);

    // No further requests: writer stays idle.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i % 8 == 0) begin
        check("final_idle_bus", {sio_c, sio_d_out, sio_d_oe, busy, sccb_ok}, 5'b11100);
        check("final_idle_state", state_dbg, ST_IDLE);
      end
    end

    check("ok_count", ok_cnt, NW);
    check("exp_q_drained", exp_q.size(), 0);
    check("lat_q_drained", lat_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sccb_writer.md
SCCB_WRITER -- requirements
Module: sccb_writer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- QUARTER, 63, clk cycles per quarter SCL period (25 MHz clk -> ~100 kHz SCL).
- DEV_ID, 8'h60, SCCB write ID byte.
- PWRUP_WAIT, 25000, clk cycles idle after reset before first transaction.
- RST_WAIT, 25000, clk cycles settle after writing RESET_WORD.
- RESET_WORD, 16'h1280, {reg,data} word that triggers RST_WAIT.
REQ-002 clk  input  1  system clock; all logic rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 reg_ok  input  1  word request; high = data_in valid and pending.
REQ-005 data_in  input  16  {reg_addr[15:8], reg_data[7:0]}.
REQ-006 sccb_ok  output  1  one-cycle pulse: current word fully written, advance.
REQ-007 busy  output  1  high from leaving IDLE until sccb_ok pulse inclusive.
REQ-008 sio_c  output  1  SCCB clock, push-pull.
REQ-009 sio_d_out  output  1  SCCB data value.
REQ-010 sio_d_oe  output  1  SCCB data drive enable; top level tri-states sio_d when low.

Function
REQ-011 States SHALL be PWRUP, IDLE, START, BIT, STOP, SETTLE, DONE, GAP.
REQ-012 PWRUP: after reset, hold bus idle PWRUP_WAIT cycles, then IDLE.
REQ-013 Bus idle (PWRUP, IDLE, SETTLE, DONE, GAP): sio_c=1, sio_d_out=1, sio_d_oe=1.
REQ-014 IDLE: when reg_ok=1, capture data_in into a 16-bit holding register, go START next cycle; reg_ok=0 stays IDLE.
REQ-015 All bus timing advances on a quarter tick every QUARTER clk cycles, restarted on leaving IDLE.
REQ-016 START, 2 quarters: q0 sio_d_out=0, sio_c=1; q1 sio_c=0.
REQ-017 BIT, 27 bits, each 4 quarters: q0-q1 sio_c=0, sio_d_out updated at q0; q2-q3 sio_c=1.
REQ-018 Bit order SHALL be DEV_ID[7:0], X, reg_addr[7:0], X, reg_data[7:0], X, MSB first.
REQ-019 X (don't-care) bits 8, 17, 26 SHALL drive sio_d_oe=0; ack level is ignored.
REQ-020 STOP, 4 quarters: q0 sio_c=0, sio_d_out=0, oe=1; q1 sio_c=1; q2-q3 sio_d_out=1.
REQ-021 Transaction length START->end of STOP SHALL be exactly 114*QUARTER cycles.
REQ-022 After STOP: captured word == RESET_WORD -> SETTLE for RST_WAIT cycles, then DONE; otherwise DONE directly.
REQ-023 DONE SHALL assert sccb_ok for exactly one cycle, then GAP.
REQ-024 GAP SHALL last 2 cycles ignoring reg_ok, because the upstream word register updates one cycle after the advance.
REQ-025 Changes of data_in/reg_ok outside IDLE SHALL NOT affect the transaction in flight.
REQ-026 Back-to-back words: next START begins no sooner than 3 cycles after sccb_ok.
REQ-027 Wait counters SHALL be sized from the largest of PWRUP_WAIT, RST_WAIT, QUARTER; no wrap-around.

Reset
REQ-028 On rst: state=PWRUP, sccb_ok=0, busy=0, sio_c=1, sio_d_out=1, sio_d_oe=1, all counters 0.
REQ-029 rst mid-transaction SHALL abort immediately to these values; the word is re-requested (no sccb_ok issued), and PWRUP_WAIT repeats.

Structure
REQ-030 Shared package sccb_pkg SHALL hold the state enum, bit count 27, X-bit indices, default DEV_ID and RESET_WORD.
REQ-031 Quarter-tick divider SHALL be sub-module sccb_tick_gen (clk, rst, en, tick); the rest is one FSM with shift/bit counters.
REQ-032 Outputs SHALL be registered; no combinational path from reg_ok/data_in to bus pins.

Verification (QUARTER=2, PWRUP_WAIT=5, RST_WAIT=10)
REQ-033 Reset release, reg_ok=1, data_in=16'hFF01 -> no bus activity for 5 cycles; at sio_c rising edges sio_d reads 0110_0000,Z,1111_1111,Z,0000_0001,Z; sccb_ok pulse once, 228 cycles after START.
REQ-034 data_in=16'h1280 -> 10 extra idle-bus cycles between STOP end and sccb_ok.
REQ-035 Model upstream counter advancing on reg_ok&&sccb_ok; 3 words -> each written exactly once, in order, none duplicated.
REQ-036 Toggle data_in during BIT -> serialized word equals value captured in IDLE.
REQ-037 Assert rst at bit 12 -> sio_c=1, sio_d_out=1, oe=1 same cycle, no sccb_ok; after release the same word is rewritten in full.
REQ-038 reg_ok=0 after last word -> state stays IDLE, bus idle, busy=0 indefinitely.
